dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port round-robin arbiter that shares the single data memory between two requesters: the pipeline MEM stage (port m0) and a secondary master such as a debug or loader port (port m1). It sits directly in front of dmem. It latches one request at a time, drives the memory control, address and write-data lines for exactly one access cycle, and returns a registered read word with a one-cycle acknowledge pulse to the winning requester.

## Interface
- ADDR_W, 8, word address width; matches dmem depth of 256 words
- DATA_W, 16, data word width
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  access request; held with its fields until the matching ack
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  word address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  DATA_W  registered read result for that port
- ram_ena  out  1  to dmem ram_ena
- wena  out  1  to dmem wena
- addr  out  ADDR_W  to dmem addr
- data_in  out  DATA_W  to dmem data_in
- ram_rdata  in  DATA_W  from dmem data_out; combinational read, valid only while ram_ena = 1

## Operation
- FSM states:
  - IDLE: memory idle; arbitrate on sampled requests.
  - ACCESS: drive the memory for one cycle.
  - DONE: pulse ack to the winner, then return to IDLE.
- IDLE transitions:
  - No request: stay in IDLE.
  - Any request: pick the winner, latch its we, addr and wdata into internal registers, record the winner, and go to ACCESS.
- Arbitration:
  - prio register names the favoured port; reset value is m0.
  - If only one port requests, that port wins.
  - If both request, the prio port wins.
  - On every grant, prio is set to the non-winning port. Result: strict alternation under contention; worst-case wait is one foreign transaction.
- ACCESS:
  - Memory outputs: ram_ena = 1, wena = latched we, addr and data_in = latched values.
  - On a write, dmem commits at the edge ending ACCESS.
  - On a read, ram_rdata is captured into the winner's rdata register at that same edge.
  - Next state is DONE.
- DONE: winner's ack = 1 for exactly this cycle; next state is IDLE.
- Outputs outside ACCESS: ram_ena = 0, wena = 0; addr and data_in hold their last values.
- rdata registers:
  - Updated only by a read granted to that port.
  - Writes and the other port's accesses leave them unchanged.
- Latched requests: a requester dropping req or changing fields after the grant does not affect the transaction. The access completes and ack is still issued.
- A req still high in the cycle after ack is a new request, arbitrated in IDLE.
- m0_ack and m1_ack are never high in the same cycle.
- At most one memory access is in flight.

## Timing
- Cycle numbering: cycle n lies between clock edges n and n+1. A request visible in IDLE in cycle 0 produces:
  - ACCESS in cycle 1; write commits or read data is captured at edge 2.
  - ack and valid rdata in cycle 2.
  - IDLE in cycle 3.
- Latency: 2 cycles from request sampled to ack. Throughput: one access per 3 cycles.
- Reset (rst_n = 0, asynchronous, effective immediately):
  - State = IDLE, prio = m0, latched registers = 0.
  - ram_ena = 0, wena = 0, addr = 0, data_in = 0.
  - m0_ack = m1_ack = 0, m0_rdata = m1_rdata = 0.
- Reset during ACCESS: ram_ena and wena fall immediately and no dmem write occurs. The transaction is discarded with no ack; requesters must reissue after reset.
- Reset during DONE: ack drops immediately.
- Release: the first grant is possible in the first cycle after rst_n rises.

## Test plan
- Reset: hold rst_n = 0 with random inputs -> every output listed above reads 0 and no ack occurs.
- Write then read on m0:
  - m0 writes addr 0x12, data 0xBEEF -> m0_ack in cycle 2.
  - m0 then reads 0x12 -> m0_ack 2 cycles after sampling, with m0_rdata = 0xBEEF.
  - m1_rdata stays 0 throughout.
- Contention: after reset, m0 and m1 both hold req continuously with distinct addresses -> grants alternate m0, m1, m0, m1; acks arrive in cycles 2, 5, 8, 11; no cycle has both acks.
- Solo back-to-back: m1 alone holds req while reading 0x00..0x03 -> one m1_ack every 3 cycles; each rdata equals the preloaded word; m0_ack stays 0.
- Request dropped mid-transaction: m0 requests a write of 0x5A5A to 0x20, then drops req during ACCESS -> m0_ack is still pulsed in cycle 2 and a later read of 0x20 returns 0x5A5A.
- Reset mid-access: m1 writes 0x1234 to 0x40 (old value 0x0000) and rst_n falls during ACCESS -> ram_ena = 0 immediately, no m1_ack, and a post-reset read of 0x40 returns 0x0000.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester and data-memory signal bundle for dmem_arbiter.
// slave = arbiter view; master = requesters plus dmem model view.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic              ram_ena;
    logic              wena;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  ram_rdata,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output ram_ena, wena, addr, data_in
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output ram_rdata,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  ram_ena, wena, addr, data_in
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// One latched transaction at a time: IDLE -> ACCESS (one memory cycle) -> DONE (ack).
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e            state_q;
    logic              prio_q;      // 0 = m0 favoured, 1 = m1 favoured
    logic              win_q;       // port owning the in-flight transaction
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ram_ena_q;
    logic              wena_q;
    logic              ack0_q;
    logic              ack1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic              any_req_c;
    logic              grant_c;
    logic              sel_we_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;

    // Winner selection: a lone requester wins, ties go to the favoured port.
    always_comb begin
        any_req_c   = bus.m0_req | bus.m1_req;
        grant_c     = (bus.m0_req && bus.m1_req) ? prio_q : bus.m1_req;
        sel_we_c    = grant_c ? bus.m1_we    : bus.m0_we;
        sel_addr_c  = grant_c ? bus.m1_addr  : bus.m0_addr;
        sel_wdata_c = grant_c ? bus.m1_wdata : bus.m0_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ram_ena_q <= 1'b0;
            wena_q    <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            ram_ena_q <= 1'b0;
            wena_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req_c) begin
                        win_q     <= grant_c;
                        prio_q    <= ~grant_c;
                        we_q      <= sel_we_c;
                        addr_q    <= sel_addr_c;
                        wdata_q   <= sel_wdata_c;
                        ram_ena_q <= 1'b1;
                        wena_q    <= sel_we_c;
                        state_q   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Memory read is combinational; capture at the edge closing ACCESS.
                    if (!we_q) begin
                        if (win_q) rdata1_q <= bus.ram_rdata;
                        else       rdata0_q <= bus.ram_rdata;
                    end
                    if (win_q) ack1_q <= 1'b1;
                    else       ack0_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // addr/data_in come straight from the latched request so they hold between accesses.
    assign bus.ram_ena  = ram_ena_q;
    assign bus.wena     = wena_q;
    assign bus.addr     = addr_q;
    assign bus.data_in  = wdata_q;
    assign bus.m0_ack   = ack0_q;
    assign bus.m1_ack   = ack1_q;
    assign bus.m0_rdata = rdata0_q;
    assign bus.m1_rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, scoreboard on acks,
// and directed sequences for contention, back-to-back, dropped req and reset mid-access.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Data memory: combinational read while enabled, write at the rising edge.
    logic [DATA_W-1:0] mem [256];
    assign bus.ram_rdata = bus.ram_ena ? mem[bus.addr] : 16'hDEAD;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i < 4) ? 16'(16'h1000 + i) : 16'h0000;
        end else if (bus.ram_ena && bus.wena) begin
            mem[bus.addr] <= bus.data_in;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic              port;
        logic              we;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    exp_t              sb_q[$];
    exp_t              sb_e;
    logic [DATA_W-1:0] last_rd [2];

    // Scoreboard: every ack must match the oldest expected transaction.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_rd[0] = '0;
            last_rd[1] = '0;
        end else if (bus.m0_ack || bus.m1_ack) begin
            chk("ack_exclusive", 64'(bus.m0_ack & bus.m1_ack), 64'd0);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=%b%b required=none at %0t",
                         bus.m0_ack, bus.m1_ack, $time);
            end else begin
                sb_e = sb_q.pop_front();
                chk("ack_port", 64'(bus.m1_ack), 64'(sb_e.port));
                if (!sb_e.we) last_rd[sb_e.port] = sb_e.rdata;
                chk("m0_rdata", 64'(bus.m0_rdata), 64'(last_rd[0]));
                chk("m1_rdata", 64'(bus.m1_rdata), 64'(last_rd[1]));
            end
        end
    end

    task automatic issue(input bit port, input bit we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_rd,
                         input bit push);
        exp_t e;
        e.port = port; e.we = we; e.rdata = exp_rd;
        if (push) sb_q.push_back(e);
        if (port) begin
            bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
        end else begin
            bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
        end
    endtask

    task automatic drop(input bit port);
        if (port) begin
            bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        end else begin
            bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        end
    endtask

    // Count rising edges until the port's ack is seen; bounded.
    task automatic wait_ack(input bit port, input int exp_cyc, input string name);
        int n = 0;
        bit got = 1'b0;
        while (!got && n < 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (port ? bus.m1_ack : bus.m0_ack) got = 1'b1;
        end
        chk(name, 64'(got ? n : 99), 64'(exp_cyc));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit                port;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rd;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{1'b0, 1'b1, 8'h12, 16'hBEEF, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 8'h12, 16'h0000, 16'hBEEF};
        vecs[2] = '{1'b1, 1'b1, 8'h30, 16'h1111, 16'h0000};
        vecs[3] = '{1'b1, 1'b0, 8'h30, 16'h0000, 16'h1111};
        vecs[4] = '{1'b0, 1'b0, 8'h30, 16'h0000, 16'h1111};
        vecs[5] = '{1'b1, 1'b1, 8'h12, 16'h0F0F, 16'h0000};
        vecs[6] = '{1'b0, 1'b0, 8'h12, 16'h0000, 16'h0F0F};
        vecs[7] = '{1'b0, 1'b1, 8'hFF, 16'hFFFF, 16'h0000};
        vecs[8] = '{1'b1, 1'b0, 8'hFF, 16'h0000, 16'hFFFF};
        vecs[9] = '{1'b1, 1'b0, 8'h03, 16'h0000, 16'h1003};

        drop(1'b0);
        drop(1'b1);

        // Reset held with random inputs: all outputs stay zero.
        @(posedge clk);
        #1 preload = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.m0_req = 1'($urandom); bus.m0_we = 1'($urandom);
            bus.m0_addr = 8'($urandom); bus.m0_wdata = 16'($urandom);
            bus.m1_req = 1'($urandom); bus.m1_we = 1'($urandom);
            bus.m1_addr = 8'($urandom); bus.m1_wdata = 16'($urandom);
            @(negedge clk);
            chk("reset_outputs",
                {4'h0, bus.m0_ack, bus.m1_ack, bus.m0_rdata, bus.m1_rdata,
                 bus.ram_ena, bus.wena, bus.addr, bus.data_in}, 64'd0);
            @(posedge clk);
            #1;
        end
        drop(1'b0);
        drop(1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: single-requester transactions, 2-cycle latency each.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 issue(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 1'b1);
            wait_ack(vecs[i].port, 2, $sformatf("vec%0d_latency", i));
            @(posedge clk);
            #1 drop(vecs[i].port);
        end
        @(negedge clk);
        chk("idle_mem_ctrl", {bus.ram_ena, bus.wena, bus.addr}, {2'b00, 8'h03});

        // Contention right after reset: m0, m1, m0, m1 at cycles 2, 5, 8, 11.
        do_reset();
        @(posedge clk);
        #1;
        sb_q.push_back('{1'b0, 1'b0, 16'h1001});
        sb_q.push_back('{1'b1, 1'b0, 16'h1002});
        sb_q.push_back('{1'b0, 1'b0, 16'h1001});
        sb_q.push_back('{1'b1, 1'b0, 16'h1002});
        issue(1'b0, 1'b0, 8'h01, 16'h0, 16'h1001, 1'b0);
        issue(1'b1, 1'b0, 8'h02, 16'h0, 16'h1002, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            logic [1:0] exp_ack;
            @(posedge clk);
            @(negedge clk);
            exp_ack = (c == 2 || c == 8) ? 2'b10 : (c == 5 || c == 11) ? 2'b01 : 2'b00;
            chk($sformatf("contention_c%0d", c), 64'({bus.m0_ack, bus.m1_ack}), 64'(exp_ack));
        end
        @(posedge clk);
        #1 drop(1'b0);
        drop(1'b1);

        // Solo back-to-back reads by m1 with req held high.
        @(posedge clk);
        #1 issue(1'b1, 1'b0, 8'h00, 16'h0, 16'h1000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            wait_ack(1'b1, 2, $sformatf("solo%0d_spacing", k));
            @(posedge clk);
            if (k < 3) #1 issue(1'b1, 1'b0, 8'(k + 1), 16'h0, 16'(16'h1001 + k), 1'b1);
            else       #1 drop(1'b1);
        end

        // Request dropped and fields scrambled during ACCESS.
        @(posedge clk);
        #1 issue(1'b0, 1'b1, 8'h20, 16'h5A5A, 16'h0, 1'b1);
        @(posedge clk);
        #1;
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = 8'h99; bus.m0_wdata = 16'h0000;
        chk("drop_access_bus", {bus.ram_ena, bus.wena, bus.addr, bus.data_in},
            {1'b1, 1'b1, 8'h20, 16'h5A5A});
        wait_ack(1'b0, 1, "drop_ack");
        @(posedge clk);
        #1 issue(1'b0, 1'b0, 8'h20, 16'h0, 16'h5A5A, 1'b1);
        wait_ack(1'b0, 2, "drop_readback");
        @(posedge clk);
        #1 drop(1'b0);

        // Reset during ACCESS: write discarded, no ack.
        @(posedge clk);
        #1 issue(1'b1, 1'b1, 8'h40, 16'h1234, 16'h0, 1'b0);
        @(posedge clk);
        #1 chk("rst_mid_ena_before", 64'(bus.ram_ena), 64'd1);
        rst_n = 1'b0;
        #1 chk("rst_mid_ctrl_after", 64'({bus.ram_ena, bus.wena}), 64'd0);
        drop(1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_no_ack", 64'({bus.m0_ack, bus.m1_ack}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 issue(1'b1, 1'b0, 8'h40, 16'h0, 16'h0000, 1'b1);
        wait_ack(1'b1, 2, "rst_mid_readback");
        @(posedge clk);
        #1 drop(1'b1);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
